// File: rtl/mmcm_ps_servo_ctrl.sv
// Fine-phase servo for the MMCM dynamic phase-shift port: integrates detector
// lead/lag decisions and issues single PSEN steps with PSDONE timeout handling.
module mmcm_ps_servo_ctrl #(
  parameter int THRESH  = 64,
  parameter int ACC_W   = 12,
  parameter int HOLDOFF = 16,
  parameter int TIMEOUT = 255,
  parameter int SETTLE  = 256
) (
  input  logic               clk_in_300Mhz,
  input  logic               reset_in,
  input  logic               enable,
  input  logic               mmcm_locked,
  input  logic               pd_valid,
  input  logic               pd_lead,
  output logic               psen,
  output logic               psincdec,
  input  logic               psdone,
  output logic signed [15:0] ps_count,
  output logic               servo_settled,
  output logic               ps_fault
);

  localparam int CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SET_W   = $clog2(SETTLE + 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = $signed(ACC_W'((1 << (ACC_W - 1)) - 1));
  localparam logic signed [ACC_W-1:0] ACC_THR = $signed(ACC_W'(THRESH));
  localparam logic signed [15:0]      PS_MAX  = 16'sd32767;
  localparam logic [CNT_W-1:0]        TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]        HO_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [SET_W-1:0]        SET_V   = SET_W'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRACK = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [SET_W-1:0]         settle_q, settle_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     dir_q, dir_d;
  logic signed [15:0]       count_q, count_d;
  logic                     fault_q, fault_d;
  logic                     psen_q, psen_d;
  logic                     psincdec_q, psincdec_d;
  logic                     settled_q, settled_d;

  function automatic logic signed [ACC_W-1:0] acc_step(input logic signed [ACC_W-1:0] a,
                                                       input logic up);
    if (up) return (a == ACC_MAX) ? a : a + $signed(ACC_W'(1));
    else    return (a == -ACC_MAX) ? a : a - $signed(ACC_W'(1));
  endfunction

  function automatic logic signed [15:0] count_step(input logic signed [15:0] c,
                                                    input logic up);
    if (up) return (c == PS_MAX) ? c : c + 16'sd1;
    else    return (c == -PS_MAX) ? c : c - 16'sd1;
  endfunction

  always_ff @(posedge clk_in_300Mhz or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      settled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
      psen_q     <= psen_d;
      psincdec_q <= psincdec_d;
      settled_q  <= settled_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    count_d  = count_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE: begin
        acc_d    = '0;
        settle_d = '0;
        if (enable && mmcm_locked) state_d = S_TRACK;
      end
      S_TRACK: begin
        // Threshold is judged on the registered accumulator, so a sample in the
        // transition cycle is dropped along with the cleared accumulator.
        if (acc_q >= ACC_THR || acc_q <= -ACC_THR) begin
          state_d  = S_REQ;
          dir_d    = ~acc_q[ACC_W-1];
          acc_d    = '0;
          settle_d = '0;
        end else if (pd_valid) begin
          acc_d = acc_step(acc_q, ~pd_lead);
          if (settle_q != SET_V) settle_d = settle_q + SET_W'(1);
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (psdone) begin
          count_d = count_step(count_q, dir_q);
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HO_LAST) state_d = S_TRACK;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FAULT: begin
        if (!enable) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Losing enable or lock abandons any outstanding step without counting it.
    if (state_q != S_IDLE && state_q != S_FAULT && !(enable && mmcm_locked)) begin
      state_d  = S_IDLE;
      count_d  = count_q;
      acc_d    = '0;
      settle_d = '0;
    end
  end

  always_comb begin
    psen_d     = (state_d == S_REQ);
    psincdec_d = (state_d == S_REQ || state_d == S_WAIT) ? dir_d : 1'b0;
    settled_d  = (state_d == S_TRACK) && (settle_d == SET_V);
  end

  assign psen          = psen_q;
  assign psincdec      = psincdec_q;
  assign ps_count      = count_q;
  assign servo_settled = settled_q;
  assign ps_fault      = fault_q;

endmodule

// File: tb/tb_mmcm_ps_servo_ctrl.sv
// Scenario bench for mmcm_ps_servo_ctrl: directed servo scenarios plus a random
// lead/lag walk checked against an integer accumulator model.
module tb_mmcm_ps_servo_ctrl;
  localparam int THRESH  = 64;
  localparam int HOLDOFF = 16;
  localparam int TIMEOUT = 255;
  localparam int SETTLE  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        locked = 1'b0;
  logic        pd_valid = 1'b0;
  logic        pd_lead = 1'b0;
  logic        psdone = 1'b0;
  logic        psen, psincdec, servo_settled, ps_fault;
  logic [15:0] ps_count;

  int total = 0;
  int bad = 0;
  int psen_cnt = 0;
  int exp_count = 0;

  mmcm_ps_servo_ctrl #(
    .THRESH(THRESH), .ACC_W(12), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
  ) dut (
    .clk_in_300Mhz(clk), .reset_in(rst), .enable(enable), .mmcm_locked(locked),
    .pd_valid(pd_valid), .pd_lead(pd_lead), .psen(psen), .psincdec(psincdec),
    .psdone(psdone), .ps_count(ps_count), .servo_settled(servo_settled),
    .ps_fault(ps_fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (psen === 1'b1) psen_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    locked = 1'b1;
    tick();
  endtask

  task automatic send(input logic lead);
    pd_valid = 1'b1;
    pd_lead  = lead;
    tick();
    pd_valid = 1'b0;
  endtask

  task automatic pulse_done();
    psdone = 1'b1;
    tick();
    psdone = 1'b0;
  endtask

  task automatic wait_psen(input int budget, output bit found, output logic dir);
    found = 1'b0;
    dir   = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (psen === 1'b1) begin
        found = 1'b1;
        dir   = psincdec;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (psen !== 1'b0) begin bad++; $display("FAIL reset_psen got=%b want=0", psen); end
    total++; if (psincdec !== 1'b0) begin bad++; $display("FAIL reset_psincdec got=%b want=0", psincdec); end
    total++; if (ps_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", $signed(ps_count)); end
    total++; if (servo_settled !== 1'b0) begin bad++; $display("FAIL reset_settled got=%b want=0", servo_settled); end
    total++; if (ps_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", ps_fault); end
    rst = 1'b0;
    exp_count = 0;
    tick();
  endtask

  task automatic test_single_step();
    int   base;
    bit   f;
    logic d;
    restart();
    base = psen_cnt;
    for (int i = 0; i < THRESH - 1; i++) begin
      send(1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    send(1'b0);
    tick();
    total++; if (psen !== 1'b1) begin bad++; $display("FAIL step_latency psen got=%b want=1", psen); end
    total++; if (psincdec !== 1'b1) begin bad++; $display("FAIL step_dir got=%b want=1", psincdec); end
    tick();
    total++; if (psen !== 1'b0) begin bad++; $display("FAIL step_one_cycle psen got=%b want=0", psen); end
    repeat (10) tick();
    pulse_done();
    exp_count++;
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL step_count got=%0d want=%0d", $signed(ps_count), exp_count); end
    repeat (60) tick();
    total++; if (psen_cnt - base !== 1) begin bad++; $display("FAIL step_no_extra pulses got=%0d want=1", psen_cnt - base); end
    for (int i = 0; i < THRESH - 1; i++) send(1'b0);
    repeat (4) tick();
    total++; if (psen_cnt - base !== 1) begin bad++; $display("FAIL step_acc_cleared pulses got=%0d want=1", psen_cnt - base); end
    send(1'b0);
    wait_psen(4, f, d);
    total++; if (!f || d !== 1'b1) begin bad++; $display("FAIL step_second found=%0d dir=%b want found=1 dir=1", f, d); end
    repeat (3) tick();
    pulse_done();
    exp_count++;
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL step_count2 got=%0d want=%0d", $signed(ps_count), exp_count); end
    repeat (HOLDOFF) tick();
  endtask

  task automatic test_settle();
    int base;
    restart();
    base = psen_cnt;
    for (int i = 1; i <= 1000; i++) begin
      send((i % 2 == 1) ? 1'b0 : 1'b1);
      if (i == SETTLE - 1) begin
        total++; if (servo_settled !== 1'b0) begin bad++; $display("FAIL settle_early got=%b want=0", servo_settled); end
      end
      if (i == SETTLE) begin
        total++; if (servo_settled !== 1'b1) begin bad++; $display("FAIL settle_rise got=%b want=1", servo_settled); end
      end
    end
    repeat (3) tick();
    total++; if (psen_cnt !== base) begin bad++; $display("FAIL settle_no_psen pulses got=%0d want=0", psen_cnt - base); end
    total++; if (servo_settled !== 1'b1) begin bad++; $display("FAIL settle_hold got=%b want=1", servo_settled); end
  endtask

  task automatic test_decrement_holdoff();
    int   base;
    bit   f;
    logic d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    restart();
    base = psen_cnt;
    for (int i = 0; i < THRESH; i++) send(1'b1);
    wait_psen(4, f, d);
    total++; if (!f || d !== 1'b0) begin bad++; $display("FAIL dec_first found=%0d dir=%b want found=1 dir=0", f, d); end
    repeat (2) tick();
    pulse_done();
    exp_count--;
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL dec_count1 got=%0d want=%0d", $signed(ps_count), exp_count); end
    for (int i = 0; i < HOLDOFF; i++) begin
      pd_valid = 1'b1;
      pd_lead  = 1'b1;
      tick();
    end
    pd_valid = 1'b0;
    for (int i = 0; i < THRESH - 1; i++) send(1'b1);
    repeat (5) tick();
    total++; if (psen_cnt - base !== 1) begin bad++; $display("FAIL dec_holdoff_ignored pulses got=%0d want=1", psen_cnt - base); end
    send(1'b1);
    wait_psen(4, f, d);
    total++; if (!f || d !== 1'b0) begin bad++; $display("FAIL dec_second found=%0d dir=%b want found=1 dir=0", f, d); end
    repeat (5) tick();
    pulse_done();
    exp_count--;
    total++; if (ps_count !== 16'hFFFE) begin bad++; $display("FAIL dec_count2 got=%0d want=-2", $signed(ps_count)); end
    repeat (HOLDOFF) tick();
  endtask

  task automatic test_timeout_fault();
    int   base;
    bit   f;
    logic d;
    restart();
    base = psen_cnt;
    for (int i = 0; i < THRESH; i++) send(1'b0);
    wait_psen(4, f, d);
    total++; if (!f) begin bad++; $display("FAIL to_req found=%0d want=1", f); end
    tick();
    repeat (TIMEOUT - 1) tick();
    total++; if (ps_fault !== 1'b0) begin bad++; $display("FAIL to_early fault got=%b want=0", ps_fault); end
    tick();
    total++; if (ps_fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%b want=1", ps_fault); end
    repeat (40) tick();
    pulse_done();
    total++; if (psen_cnt - base !== 1) begin bad++; $display("FAIL to_no_psen pulses got=%0d want=1", psen_cnt - base); end
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL to_count got=%0d want=%0d", $signed(ps_count), exp_count); end
    total++; if (ps_fault !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", ps_fault); end
    enable = 1'b0;
    tick();
    total++; if (ps_fault !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", ps_fault); end
    enable = 1'b1;
    tick();
    for (int i = 0; i < THRESH; i++) send(1'b0);
    wait_psen(4, f, d);
    total++; if (!f || d !== 1'b1) begin bad++; $display("FAIL to_retrack found=%0d dir=%b want found=1 dir=1", f, d); end
    repeat (5) tick();
    pulse_done();
    exp_count++;
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL to_retrack_count got=%0d want=%0d", $signed(ps_count), exp_count); end
    repeat (HOLDOFF) tick();
  endtask

  task automatic test_timeout_race();
    bit   f;
    logic d;
    restart();
    for (int i = 0; i < THRESH; i++) send(1'b1);
    wait_psen(4, f, d);
    total++; if (!f || d !== 1'b0) begin bad++; $display("FAIL race_req found=%0d dir=%b want found=1 dir=0", f, d); end
    tick();
    repeat (TIMEOUT - 1) tick();
    pulse_done();
    exp_count--;
    total++; if (ps_fault !== 1'b0) begin bad++; $display("FAIL race_fault got=%b want=0", ps_fault); end
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL race_count got=%0d want=%0d", $signed(ps_count), exp_count); end
    repeat (HOLDOFF) tick();
  endtask

  task automatic test_unlock_abandon();
    int   base;
    bit   f;
    logic d;
    restart();
    base = psen_cnt;
    for (int i = 0; i < THRESH; i++) send(1'b0);
    wait_psen(4, f, d);
    total++; if (!f) begin bad++; $display("FAIL unlock_req found=%0d want=1", f); end
    repeat (4) tick();
    locked = 1'b0;
    tick();
    repeat (2) tick();
    pulse_done();
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL unlock_count got=%0d want=%0d", $signed(ps_count), exp_count); end
    locked = 1'b1;
    tick();
    for (int i = 0; i < THRESH - 1; i++) send(1'b0);
    repeat (4) tick();
    total++; if (psen_cnt - base !== 1) begin bad++; $display("FAIL unlock_acc_zero pulses got=%0d want=1", psen_cnt - base); end
    send(1'b0);
    wait_psen(4, f, d);
    total++; if (!f || d !== 1'b1) begin bad++; $display("FAIL unlock_relock found=%0d dir=%b want found=1 dir=1", f, d); end
    repeat (3) tick();
    pulse_done();
    exp_count++;
    total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL unlock_relock_count got=%0d want=%0d", $signed(ps_count), exp_count); end
    repeat (HOLDOFF) tick();
  endtask

  task automatic test_random();
    int   base, steps, acc, bias;
    bit   f;
    logic d, lead, want;
    restart();
    base  = psen_cnt;
    steps = 0;
    acc   = 0;
    for (int n = 0; n < 600; n++) begin
      bias = ((n / 150) % 2 == 1) ? 25 : 75;
      lead = ($urandom_range(0, 99) < bias);
      send(lead);
      acc += lead ? -1 : 1;
      if (acc >= THRESH || acc <= -THRESH) begin
        want = (acc > 0);
        wait_psen(4, f, d);
        total++; if (!f || d !== want) begin bad++; $display("FAIL rand_step found=%0d dir=%b want dir=%b", f, d, want); end
        steps++;
        exp_count += want ? 1 : -1;
        repeat ($urandom_range(1, 20)) tick();
        pulse_done();
        total++; if (ps_count !== 16'(exp_count)) begin bad++; $display("FAIL rand_count got=%0d want=%0d", $signed(ps_count), exp_count); end
        repeat (HOLDOFF) tick();
        acc = 0;
      end else begin
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    repeat (10) tick();
    total++; if (psen_cnt - base !== steps) begin bad++; $display("FAIL rand_pulses got=%0d want=%0d", psen_cnt - base, steps); end
  endtask

  task automatic test_async_reset();
    bit   f;
    logic d;
    restart();
    for (int i = 0; i < THRESH; i++) send(1'b0);
    wait_psen(4, f, d);
    repeat (2) tick();
    pulse_done();
    exp_count++;
    total++; if (!f || ps_count !== 16'(exp_count)) begin bad++; $display("FAIL areset_pre found=%0d count=%0d want=%0d", f, $signed(ps_count), exp_count); end
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if (ps_count !== 16'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", $signed(ps_count)); end
    total++; if (psen !== 1'b0 || psincdec !== 1'b0) begin bad++; $display("FAIL areset_ps got=%b%b want=00", psen, psincdec); end
    total++; if (servo_settled !== 1'b0 || ps_fault !== 1'b0) begin bad++; $display("FAIL areset_flags got=%b%b want=00", servo_settled, ps_fault); end
    tick();
    rst = 1'b0;
    exp_count = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_settle();
    test_decrement_holdoff();
    test_timeout_fault();
    test_timeout_race();
    test_unlock_abandon();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
